sa_feeder: RTL and testbench

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_feeder_if.sv | 33 +++
 rtl/sa_feeder.sv | 158 +++++++++++++++
 tb/tb_sa_feeder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sa_feeder_if.sv
// Handshake and edge-lane bundle between the systolic-array feeder and its
// surroundings: job control, weight/activation streams, PE edge drives.
interface sa_feeder_if #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int MUL_BW = 16,
   parameter int ADD_BW = 32
);
   logic                     i_start;
   logic [15:0]              i_num_vec;
   logic                     i_wt_valid;
   logic                     o_wt_ready;
   logic [COLS*MUL_BW-1:0]   i_wt_data;
   logic                     i_act_valid;
   logic                     o_act_ready;
   logic [ROWS*MUL_BW-1:0]   i_act_data;
   logic                     o_mode;
   logic [COLS*ADD_BW-1:0]   o_top;
   logic [ROWS*MUL_BW-1:0]   o_left;
   logic [ROWS-1:0]          o_left_vld;
   logic                     o_busy;
   logic                     o_done;

   modport master (
      output i_start, i_num_vec, i_wt_valid, i_wt_data, i_act_valid, i_act_data,
      input  o_wt_ready, o_act_ready, o_mode, o_top, o_left, o_left_vld, o_busy, o_done
   );

   modport slave (
      input  i_start, i_num_vec, i_wt_valid, i_wt_data, i_act_valid, i_act_data,
      output o_wt_ready, o_act_ready, o_mode, o_top, o_left, o_left_vld, o_busy, o_done
   );
endinterface

// File: rtl/sa_feeder.sv
// Feeds a ROWS x COLS weight-stationary systolic array: buffers a weight tile,
// pushes it down the top edge, then streams skewed activations into the left edge.
module sa_feeder #(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int MUL_BW    = 16,
   parameter int ADD_BW    = 32,
   parameter int DRAIN_CYC = 8
) (
   input  logic       clk,
   input  logic       rst,
   sa_feeder_if.slave bus
);
   localparam int              SW         = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int              DRAIN_LEN  = ROWS - 1 + DRAIN_CYC;
   localparam logic [SW-1:0]   LAST_SLOT  = SW'(ROWS - 1);
   localparam logic [15:0]     DRAIN_LAST = 16'(DRAIN_LEN - 1);

   typedef enum logic [2:0] {IDLE, WT_COLLECT, WT_PUSH, STREAM, DRAIN, DONE} state_t;

   state_t                 state;
   logic [SW-1:0]          slot;
   logic [15:0]            num_vec;
   logic [15:0]            vec_cnt;
   logic [15:0]            drain_cnt;
   logic [COLS*MUL_BW-1:0] wt_buf [ROWS];
   logic                   wt_hs;
   logic                   act_hs;

   function automatic logic [COLS*ADD_BW-1:0] zext_row(input logic [COLS*MUL_BW-1:0] row);
      logic [COLS*ADD_BW-1:0] res;
      res = '0;
      for (int c = 0; c < COLS; c++)
         res[c*ADD_BW +: ADD_BW] = ADD_BW'(row[c*MUL_BW +: MUL_BW]);
      return res;
   endfunction

   assign wt_hs  = bus.i_wt_valid && bus.o_wt_ready;
   assign act_hs = bus.i_act_valid && bus.o_act_ready;

   always_ff @(posedge clk) begin
      if (wt_hs)
         wt_buf[slot] <= bus.i_wt_data;
   end

   // slot counts up while collecting, then back down while pushing so the
   // last-collected row enters the top edge first and settles in the top PE row.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         slot            <= '0;
         num_vec         <= '0;
         vec_cnt         <= '0;
         drain_cnt       <= '0;
         bus.o_mode      <= 1'b1;
         bus.o_top       <= '0;
         bus.o_wt_ready  <= 1'b0;
         bus.o_act_ready <= 1'b0;
         bus.o_busy      <= 1'b0;
         bus.o_done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  state          <= WT_COLLECT;
                  num_vec        <= bus.i_num_vec;
                  slot           <= '0;
                  vec_cnt        <= '0;
                  bus.o_wt_ready <= 1'b1;
                  bus.o_busy     <= 1'b1;
               end
            end
            WT_COLLECT: begin
               if (wt_hs) begin
                  if (slot == LAST_SLOT) begin
                     state          <= WT_PUSH;
                     bus.o_wt_ready <= 1'b0;
                     bus.o_mode     <= 1'b0;
                     bus.o_top      <= zext_row(bus.i_wt_data);
                  end else begin
                     slot <= slot + SW'(1);
                  end
               end
            end
            WT_PUSH: begin
               if (slot != '0) begin
                  slot      <= slot - SW'(1);
                  bus.o_top <= zext_row(wt_buf[slot - SW'(1)]);
               end else begin
                  bus.o_mode <= 1'b1;
                  bus.o_top  <= '0;
                  if (num_vec != 16'd0) begin
                     state           <= STREAM;
                     bus.o_act_ready <= 1'b1;
                  end else begin
                     state      <= DONE;
                     bus.o_done <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (act_hs) begin
                  vec_cnt <= vec_cnt + 16'd1;
                  if (vec_cnt == num_vec - 16'd1) begin
                     bus.o_act_ready <= 1'b0;
                     drain_cnt       <= '0;
                     if (DRAIN_LEN == 0) begin
                        state      <= DONE;
                        bus.o_done <= 1'b1;
                     end else begin
                        state <= DRAIN;
                     end
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state      <= DONE;
                  bus.o_done <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + 16'd1;
               end
            end
            DONE: begin
               state      <= IDLE;
               bus.o_done <= 1'b0;
               bus.o_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Triangular skew: row r delays its lane by r extra cycles; idle cycles inject zero bubbles.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [MUL_BW-1:0] dat_p [r+1];
      logic              vld_p [r+1];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s <= r; s++) begin
               dat_p[s] <= '0;
               vld_p[s] <= 1'b0;
            end
         end else begin
            dat_p[0] <= act_hs ? bus.i_act_data[r*MUL_BW +: MUL_BW] : '0;
            vld_p[0] <= act_hs;
            for (int s = 1; s <= r; s++) begin
               dat_p[s] <= dat_p[s-1];
               vld_p[s] <= vld_p[s-1];
            end
         end
      end

      assign bus.o_left[r*MUL_BW +: MUL_BW] = dat_p[r];
      assign bus.o_left_vld[r]              = vld_p[r];
   end
endmodule

// File: tb/tb_sa_feeder.sv
// Directed self-checking bench for sa_feeder (4x4 array, 16-bit lanes, 32-bit top lanes).
module tb_sa_feeder;
   localparam int ROWS = 4, COLS = 4, MUL_BW = 16, ADD_BW = 32, DRAIN_CYC = 8;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   sa_feeder_if #(.ROWS(ROWS), .COLS(COLS), .MUL_BW(MUL_BW), .ADD_BW(ADD_BW)) bus ();

   sa_feeder #(.ROWS(ROWS), .COLS(COLS), .MUL_BW(MUL_BW), .ADD_BW(ADD_BW), .DRAIN_CYC(DRAIN_CYC))
      dut (.clk(clk), .rst(rst), .bus(bus.slave));

   localparam logic [63:0] ACT_A = 64'hA003_A002_A001_A000;
   localparam logic [63:0] ACT_B = 64'hB003_B002_B001_B000;
   localparam logic [63:0] ACT_C = 64'hC003_C002_C001_C000;
   localparam logic [63:0] ACT_D = 64'hD003_D002_D001_D000;

   logic [63:0]  wt_rows [4];
   logic [127:0] top_exp [4];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start_job(input logic [15:0] n);
      bus.i_start   = 1'b1;
      bus.i_num_vec = n;
      step();
      bus.i_start   = 1'b0;
   endtask

   task automatic send_weights(input bit gaps);
      for (int k = 0; k < 4; k++) begin
         if (gaps && k != 0) begin
            bus.i_wt_valid = 1'b0;
            bus.i_wt_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            step();
         end
         bus.i_wt_valid = 1'b1;
         bus.i_wt_data  = wt_rows[k];
         for (int n = 0; n < 32 && bus.o_wt_ready !== 1'b1; n++) step();
         step();
      end
      bus.i_wt_valid = 1'b0;
      bus.i_wt_data  = '0;
   endtask

   task automatic wait_act_ready();
      for (int n = 0; n < 32 && bus.o_act_ready !== 1'b1; n++) step();
   endtask

   task automatic wait_done();
      for (int n = 0; n < 48 && bus.o_done !== 1'b1; n++) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_start = 1'b0; bus.i_num_vec = '0; bus.i_wt_valid = 1'b0; bus.i_wt_data = '0;
      bus.i_act_valid = 1'b0; bus.i_act_data = '0;
      step(); step(); step();
      total_cnt++; if (bus.o_mode !== 1'b1) $display("FAIL rst_mode: got %b want 1", bus.o_mode); else pass_cnt++;
      total_cnt++; if (bus.o_top !== '0) $display("FAIL rst_top: got %h want 0", bus.o_top); else pass_cnt++;
      total_cnt++; if (bus.o_left !== '0) $display("FAIL rst_left: got %h want 0", bus.o_left); else pass_cnt++;
      total_cnt++; if (bus.o_left_vld !== 4'b0) $display("FAIL rst_vld: got %b want 0000", bus.o_left_vld); else pass_cnt++;
      total_cnt++; if (bus.o_wt_ready !== 1'b0) $display("FAIL rst_wt_ready: got %b want 0", bus.o_wt_ready); else pass_cnt++;
      total_cnt++; if (bus.o_act_ready !== 1'b0) $display("FAIL rst_act_ready: got %b want 0", bus.o_act_ready); else pass_cnt++;
      total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.o_busy); else pass_cnt++;
      total_cnt++; if (bus.o_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.o_done); else pass_cnt++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_weight_push();
      start_job(16'd0);
      total_cnt++; if (bus.o_wt_ready !== 1'b1 || bus.o_busy !== 1'b1)
         $display("FAIL collect_flags: got ready=%b busy=%b want 1 1", bus.o_wt_ready, bus.o_busy); else pass_cnt++;
      send_weights(1'b1);
      for (int j = 0; j < 4; j++) begin
         total_cnt++; if (bus.o_mode !== 1'b0) $display("FAIL push_mode[%0d]: got %b want 0", j, bus.o_mode); else pass_cnt++;
         total_cnt++; if (bus.o_top !== top_exp[j]) $display("FAIL push_top[%0d]: got %h want %h", j, bus.o_top, top_exp[j]); else pass_cnt++;
         total_cnt++; if (bus.o_act_ready !== 1'b0) $display("FAIL push_act_ready[%0d]: got %b want 0", j, bus.o_act_ready); else pass_cnt++;
         step();
      end
      total_cnt++; if (bus.o_mode !== 1'b1) $display("FAIL post_push_mode: got %b want 1", bus.o_mode); else pass_cnt++;
      total_cnt++; if (bus.o_top !== '0) $display("FAIL post_push_top: got %h want 0", bus.o_top); else pass_cnt++;
      total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL zero_vec_done: got %b want 1", bus.o_done); else pass_cnt++;
      total_cnt++; if (bus.o_act_ready !== 1'b0) $display("FAIL zero_vec_act_ready: got %b want 0", bus.o_act_ready); else pass_cnt++;
      step();
      total_cnt++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0)
         $display("FAIL zero_vec_idle: got done=%b busy=%b want 0 0", bus.o_done, bus.o_busy); else pass_cnt++;
   endtask

   task automatic test_stream();
      logic [15:0] l2_exp [6] = '{16'h0, 16'h0, 16'hA002, 16'hB002, 16'hC002, 16'h0};
      logic        v2_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      start_job(16'd3);
      send_weights(1'b0);
      wait_act_ready();
      bus.i_act_valid = 1'b1;
      bus.i_act_data  = ACT_A;
      for (int i = 0; i < 6; i++) begin
         step();
         total_cnt++; if (bus.o_left[47:32] !== l2_exp[i] || bus.o_left_vld[2] !== v2_exp[i])
            $display("FAIL stream_lane2[t+%0d]: got %h/%b want %h/%b", i + 1, bus.o_left[47:32], bus.o_left_vld[2], l2_exp[i], v2_exp[i]);
         else pass_cnt++;
         if (i == 2) begin
            total_cnt++; if (bus.o_left !== 64'h0000_A002_B001_C000 || bus.o_left_vld !== 4'b0111)
               $display("FAIL stream_skew_t3: got %h/%b want 0000a002b001c000/0111", bus.o_left, bus.o_left_vld); else pass_cnt++;
            total_cnt++; if (bus.o_act_ready !== 1'b0) $display("FAIL stream_drain_ready: got %b want 0", bus.o_act_ready); else pass_cnt++;
         end
         if (i == 0) bus.i_act_data = ACT_B;
         else if (i == 1) bus.i_act_data = ACT_C;
         else begin bus.i_act_valid = 1'b0; bus.i_act_data = '0; end
      end
      wait_done();
      total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL stream_done: got %b want 1", bus.o_done); else pass_cnt++;
      step();
   endtask

   task automatic test_bubbles();
      start_job(16'd2);
      send_weights(1'b1);
      wait_act_ready();
      bus.i_act_valid = 1'b1; bus.i_act_data = ACT_A;
      step();
      total_cnt++; if (bus.o_left[15:0] !== 16'hA000 || bus.o_left_vld[0] !== 1'b1 || bus.o_act_ready !== 1'b1)
         $display("FAIL bubble_t1: got %h/%b rdy=%b want a000/1 rdy=1", bus.o_left[15:0], bus.o_left_vld[0], bus.o_act_ready); else pass_cnt++;
      bus.i_act_valid = 1'b0; bus.i_act_data = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      total_cnt++; if (bus.o_left[15:0] !== 16'h0 || bus.o_left_vld[0] !== 1'b0)
         $display("FAIL bubble_t2: got %h/%b want 0000/0", bus.o_left[15:0], bus.o_left_vld[0]); else pass_cnt++;
      bus.i_act_valid = 1'b1; bus.i_act_data = ACT_B;
      step();
      total_cnt++; if (bus.o_left[15:0] !== 16'hB000 || bus.o_left_vld[0] !== 1'b1 || bus.o_act_ready !== 1'b0)
         $display("FAIL bubble_t3: got %h/%b rdy=%b want b000/1 rdy=0", bus.o_left[15:0], bus.o_left_vld[0], bus.o_act_ready); else pass_cnt++;
      bus.i_act_valid = 1'b0; bus.i_act_data = '0;
      for (int c = 4; c <= 15; c++) begin
         step();
         total_cnt++; if (bus.o_done !== (c == 14))
            $display("FAIL bubble_done[t+%0d]: got %b want %b", c, bus.o_done, (c == 14)); else pass_cnt++;
      end
      total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL bubble_busy_end: got %b want 0", bus.o_busy); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      start_job(16'd2);
      send_weights(1'b0);
      wait_act_ready();
      bus.i_act_valid = 1'b1; bus.i_act_data = ACT_A;
      step();
      bus.i_act_valid = 1'b0; bus.i_act_data = '0;
      rst = 1'b1;
      step();
      total_cnt++;
      if ({bus.o_mode, bus.o_top, bus.o_left, bus.o_left_vld, bus.o_wt_ready, bus.o_act_ready, bus.o_busy, bus.o_done}
          !== {1'b1, 128'h0, 64'h0, 4'h0, 4'h0})
         $display("FAIL midrst_outputs: got mode=%b top=%h left=%h vld=%b wr=%b ar=%b busy=%b done=%b want mode=1 rest 0",
                  bus.o_mode, bus.o_top, bus.o_left, bus.o_left_vld, bus.o_wt_ready, bus.o_act_ready, bus.o_busy, bus.o_done);
      else pass_cnt++;
      rst = 1'b0;
      start_job(16'd1);
      total_cnt++; if (bus.o_wt_ready !== 1'b1 || bus.o_busy !== 1'b1)
         $display("FAIL midrst_restart: got ready=%b busy=%b want 1 1", bus.o_wt_ready, bus.o_busy); else pass_cnt++;
      total_cnt++; if (bus.o_left !== '0 || bus.o_left_vld !== 4'b0)
         $display("FAIL midrst_skew_clear: got %h/%b want 0/0000", bus.o_left, bus.o_left_vld); else pass_cnt++;
      send_weights(1'b1);
      total_cnt++; if (bus.o_mode !== 1'b0 || bus.o_top !== top_exp[0])
         $display("FAIL midrst_push0: got mode=%b top=%h want 0 %h", bus.o_mode, bus.o_top, top_exp[0]); else pass_cnt++;
      wait_act_ready();
      bus.i_act_valid = 1'b1; bus.i_act_data = ACT_D;
      step();
      bus.i_act_valid = 1'b0; bus.i_act_data = '0;
      step(); step(); step();
      total_cnt++; if (bus.o_left !== 64'hD003_0000_0000_0000 || bus.o_left_vld !== 4'b1000)
         $display("FAIL midrst_lane3: got %h/%b want d003000000000000/1000", bus.o_left, bus.o_left_vld); else pass_cnt++;
      wait_done();
      total_cnt++; if (bus.o_done !== 1'b1) $display("FAIL midrst_done: got %b want 1", bus.o_done); else pass_cnt++;
      step();
   endtask

   task automatic test_start_held();
      int done_cnt = 0;
      bus.i_start = 1'b1; bus.i_num_vec = 16'd1;
      step();
      bus.i_num_vec = 16'd5;
      send_weights(1'b0);
      wait_act_ready();
      bus.i_act_valid = 1'b1; bus.i_act_data = ACT_C;
      step();
      bus.i_act_valid = 1'b0; bus.i_act_data = '0;
      total_cnt++; if (bus.o_act_ready !== 1'b0 || bus.o_busy !== 1'b1)
         $display("FAIL held_count_latched: got ready=%b busy=%b want 0 1", bus.o_act_ready, bus.o_busy); else pass_cnt++;
      step();
      bus.i_start = 1'b0;
      for (int n = 0; n < 30; n++) begin
         if (bus.o_done === 1'b1) done_cnt++;
         step();
      end
      total_cnt++; if (done_cnt != 1) $display("FAIL held_done_count: got %0d want 1", done_cnt); else pass_cnt++;
      total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL held_busy_end: got %b want 0", bus.o_busy); else pass_cnt++;
   endtask

   initial begin
      wt_rows[0] = 64'h8003_8002_8001_8000;
      wt_rows[1] = 64'h8013_8012_8011_8010;
      wt_rows[2] = 64'hF023_F022_F021_F020;
      wt_rows[3] = 64'hFFFF_0032_7FFF_0030;
      top_exp[0] = 128'h0000_FFFF_0000_0032_0000_7FFF_0000_0030;
      top_exp[1] = 128'h0000_F023_0000_F022_0000_F021_0000_F020;
      top_exp[2] = 128'h0000_8013_0000_8012_0000_8011_0000_8010;
      top_exp[3] = 128'h0000_8003_0000_8002_0000_8001_0000_8000;
      test_reset();
      test_weight_push();
      test_stream();
      test_bubbles();
      test_mid_reset();
      test_start_held();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
